frequency_divider_by2: RTL and testbench



---
 rtl/frequency_divider_by2.sv | 91 +++++++++
 tb/tb_frequency_divider_by2.sv | 131 +++++++++++++
 2 files changed

// File: rtl/frequency_divider_by2.sv
// Registered 2^DIV_STAGES clock divider built as a synchronous toggle counter; out_clk is the counter MSB.
// Optional simulation checks are compiled in with `define FREQ_DIV2_ASSERT_EN.
module frequency_divider_by2 #(
  parameter int unsigned DIV_STAGES  = 1,
  parameter bit          RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  output logic out_clk
);

  localparam logic [DIV_STAGES-1:0] RESET_STATE = {DIV_STAGES{RESET_VALUE}};

  if (DIV_STAGES < 1 || DIV_STAGES > 16) begin : g_bad_stages
    $error("frequency_divider_by2: DIV_STAGES must be in 1..16");
  end

  // Stored relative to RESET_STATE so a zero power-on register already reads as RESET_VALUE.
  logic [DIV_STAGES-1:0] enc;
  logic [DIV_STAGES-1:0] s;
  logic [DIV_STAGES-1:0] s_next;
  logic [DIV_STAGES-1:0] toggle;

  assign s = enc ^ RESET_STATE;

  // Stage k toggles only when every lower stage is 1.
  always_comb begin
    toggle    = '0;
    toggle[0] = 1'b1;
    for (int unsigned k = 1; k < DIV_STAGES; k++) begin
      toggle[k] = toggle[k-1] & s[k-1];
    end
    s_next = s ^ toggle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc <= '0;
    end else begin
      enc <= s_next ^ RESET_STATE;
    end
  end

  assign out_clk = s[DIV_STAGES-1];

`ifdef FREQ_DIV2_ASSERT_EN
  localparam int unsigned HALF = 32'(1) << (DIV_STAGES - 1);

  logic        prev;
  logic        have_prev;
  logic        armed;
  logic        rst_q;
  int unsigned cnt;

  // Toggle spacing is only judged once a full half-period has been observed after reset.
  always @(posedge clk) begin
    rst_q <= rst;
    if ($isunknown(out_clk)) begin
      $display("frequency_divider_by2: out_clk is X/Z at %0t", $time);
      $error("out_clk unknown");
    end
    if (rst) begin
      have_prev <= 1'b0;
      armed     <= 1'b0;
      cnt       <= 0;
      if (rst_q && out_clk !== RESET_VALUE) begin
        $display("frequency_divider_by2: out_clk=%b during reset at %0t", out_clk, $time);
        $error("out_clk not at RESET_VALUE during reset");
      end
    end else begin
      prev      <= out_clk;
      have_prev <= 1'b1;
      if (have_prev && out_clk != prev) begin
        if (armed && cnt != HALF) begin
          $display("frequency_divider_by2: toggle after %0d edges at %0t", cnt, $time);
          $error("out_clk toggle spacing wrong");
        end
        armed <= 1'b1;
        cnt   <= 1;
      end else begin
        if (armed && cnt >= HALF) begin
          $display("frequency_divider_by2: out_clk held too long at %0t", $time);
          $error("out_clk failed to toggle");
        end
        cnt <= cnt + 1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frequency_divider_by2.sv
// Scoreboard bench for frequency_divider_by2: directed timeline pushes expected out_clk values, a monitor pops and compares.
module tb_frequency_divider_by2;

  logic clk;
  logic rst0, rst1, rst2, rst3;
  logic o0, o1, o2, o3;
  logic [3:0] outs;

  typedef struct {
    string name;
    int    sel;
    logic  exp;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  assign outs = {o3, o2, o1, o0};

  frequency_divider_by2 #(.DIV_STAGES(1), .RESET_VALUE(1'b0)) u0 (.clk(clk), .rst(rst0), .out_clk(o0));
  frequency_divider_by2 #(.DIV_STAGES(2), .RESET_VALUE(1'b0)) u1 (.clk(clk), .rst(rst1), .out_clk(o1));
  frequency_divider_by2 #(.DIV_STAGES(1), .RESET_VALUE(1'b1)) u2 (.clk(clk), .rst(rst2), .out_clk(o2));
  frequency_divider_by2 #(.DIV_STAGES(3), .RESET_VALUE(1'b0)) u3 (.clk(clk), .rst(rst3), .out_clk(o3));

  // Period 20, rising edges at 10, 30, 50, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic at(input longint t);
    if (longint'($time) < t) #(t - longint'($time));
  endtask

  task automatic push_exp(input string name, input int sel, input logic e);
    exp_t x;
    x.name = name;
    x.sel  = sel;
    x.exp  = e;
    sb.push_back(x);
    -> sample_ev;
  endtask

  // Monitor: samples the selected divider output whenever stimulus presents an expectation.
  initial begin
    exp_t x;
    logic act;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        x   = sb.pop_front();
        act = outs[x.sel];
        checks++;
        if (act !== x.exp) begin
          errors++;
          $display("FAIL %s: out_clk[%0d]=%b expected %b at %0t", x.name, x.sel, act, x.exp, $time);
        end
      end
    end
  end

  initial begin
    logic [6:0] p1;
    logic [8:0] p3;
    p1 = 7'b1100110;
    p3 = 9'b001111000;
    rst0 = 1'b0;
    rst1 = 1'b1;
    rst2 = 1'b1;
    rst3 = 1'b1;

    // Divide-by-2, reset value 0
    at(1);   push_exp("poweron", 0, 1'b0);
             push_exp("rv1_poweron_reset", 2, 1'b1);
    at(15);  push_exp("first_edge", 0, 1'b1);
    at(20);  rst0 = 1'b1;
    at(21);  push_exp("async_assert", 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      at(35 + 20 * i); push_exp("held_in_reset", 0, 1'b0);
    end
    at(120); rst0 = 1'b0;
    at(125); push_exp("pre_release_edge", 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      at(135 + 20 * i); push_exp("div2_pattern", 0, (i % 2) == 0);
    end
    at(215); push_exp("before_mid_reset", 0, 1'b1);
    at(217); rst0 = 1'b1;
    at(218); push_exp("mid_reset_async", 0, 1'b0);
    at(240); rst0 = 1'b0;
    at(255); push_exp("resume_after_reset", 0, 1'b1);

    // Divide-by-4 sequence, then reset coincident with a rising edge
    at(300); rst1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      at(315 + 20 * i); push_exp("div4_pattern", 1, p1[i]);
    end
    at(490); rst1 = 1'b1;
    at(495); push_exp("coincident_edge_reset", 1, 1'b0);
    at(515); push_exp("div4_held", 1, 1'b0);
    at(520); rst1 = 1'b0;
    at(535); push_exp("div4_release_1", 1, 1'b0);
    at(555); push_exp("div4_release_2", 1, 1'b1);

    // Reset value 1
    at(575); push_exp("rv1_in_reset", 2, 1'b1);
    at(580); rst2 = 1'b0;
    at(595); push_exp("rv1_first_edge", 2, 1'b0);
    at(615); push_exp("rv1_second_edge", 2, 1'b1);
    at(635); rst2 = 1'b1;
    at(636); push_exp("rv1_async_assert", 2, 1'b1);
    at(660); rst2 = 1'b0;
    at(675); push_exp("rv1_after_pulse", 2, 1'b0);

    // Divide-by-8 through wrap-around
    at(700); rst3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      at(715 + 20 * i); push_exp("div8_wrap", 3, p3[i]);
    end

    at(900);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
